if_fetch_unit: RTL

Instruction-fetch stage upstream of the IF/ID register of the R-type pipeline CPU.
- Owns the program counter and drives the instruction memory address.
- Buffers fetched words in a small queue and presents them to the ID stage through a valid/ready handshake.
- Supports PC redirect with queue flush, so the decode side can stall without losing fetched instructions.

---
 rtl/if_fetch_unit_pkg.sv | 21 ++
 rtl/if_fetch_unit_fetch_queue.sv | 51 +++++
 rtl/if_fetch_unit.sv | 64 ++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, constants and the fetch-queue entry layout for the IF stage.
package if_fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0;
  localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Instructions are word aligned; the low two address bits are simply dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & {{(ADDR_W-2){1'b1}}, 2'b00};
  endfunction
endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Circular-buffer FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fills the fetch queue and hands words to ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                DEPTH    = 2,
  parameter int                CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [CNT_W-1:0]   fetch_count
);
  logic [ADDR_W-1:0] pc;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign im_addr  = pc;
  assign pop      = ~empty & out_ready;
  // Redirect wins over push: the word at the old PC is stale by definition.
  assign push     = ~rst & ~redirect_valid & (~full | pop);
  assign wr_entry = '{pc: pc, instr: im_instr};

  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= word_align(redirect_pc);
    else if (push)           pc <= pc + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst)       fetch_count <= '0;
    else if (push) fetch_count <= fetch_count + 1'b1;
  end

  fetch_queue #(
    .DATA_W(ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wr_data(wr_entry),
    .rd_data(head),
    .full   (full),
    .empty  (empty)
  );

  assign out_valid = ~empty;
  assign out_instr = empty ? NOP_INSTR : head.instr;
  assign out_pc    = empty ? '0 : head.pc;
endmodule
